sincos_arbiter: RTL

- Shares one sincos (CORDIC) unit among NREQ requesters with round-robin arbitration.
- Issues at most one phase per cycle to the CORDIC and records the winner's ID in an in-order tag FIFO.
- Pops the tag when each CORDIC result returns and routes the result to the originating requester on a tagged response bus.
- Sits between the DSP-side clients and the sincos instance.

---
 rtl/sincos_arbiter_if.sv | 17 +
 rtl/sincos_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/sincos_arbiter_if.sv
// sincos_arbiter_if: requester-side phase request bus and tagged result bus of sincos_arbiter.
interface sincos_arbiter_if #(
  parameter int NREQ = 4,
  parameter int PW = 16,
  parameter int OW = 16,
  parameter int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*PW-1:0] req_phase;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [OW-1:0]      rsp_sin;
  logic [OW-1:0]      rsp_cos;
  modport master (output req_valid, req_phase, input req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos);
  modport slave (input req_valid, req_phase, output req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos);
endinterface

// File: rtl/sincos_arbiter.sv
// sincos_arbiter: round-robin sharing of one sincos unit with an in-order tag FIFO routing results back.
// Define SINCOS_ARB_STATS_EN to add per-requester saturating grant counters (o_grant_cnt, i_stats_clr).
module sincos_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = 16,
  parameter int OW = 16,
  parameter int DEPTH = 32,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sincos_arbiter_if.slave bus,
  output logic           o_cordic_rst,
  output logic           o_cordic_valid,
  output logic [PW-1:0]  o_cordic_phase,
  input  logic           i_cordic_valid,
  input  logic [OW-1:0]  i_cordic_sin,
  input  logic [OW-1:0]  i_cordic_cos,
  output logic           o_busy,
  output logic           o_err
`ifdef SINCOS_ARB_STATS_EN
  ,
  input  logic             i_stats_clr,
  output logic [NREQ*16-1:0] o_grant_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [IDW-1:0]  r_rr, w_gid, w_idx;
  logic            w_hit, w_pop;
  logic [NREQ-1:0] w_cand, w_grant;
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;
  logic [IDW-1:0]  r_tag [DEPTH];
  logic            r_cv, r_rsp_valid, r_err;
  logic [PW-1:0]   r_cp;
  logic [IDW-1:0]  r_rsp_id;
  logic [OW-1:0]   r_sin, r_cos;

  // Full mask uses the registered count, so a same-cycle pop never enables a grant.
  assign w_cand = (!i_rst_n || r_cnt == FULL) ? '0 : bus.req_valid;
  always_comb begin
    w_hit = 1'b0;
    w_gid = '0;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(r_rr) + i) % NREQ);
      if (!w_hit && w_cand[w_idx]) begin
        w_hit = 1'b1;
        w_gid = w_idx;
      end
    end
  end
  assign w_grant = w_hit ? NREQ'(1) << w_gid : '0;
  assign w_pop = i_cordic_valid && r_cnt != '0;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rr <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_cv <= 1'b0;
      r_cp <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id <= '0;
      r_sin <= '0;
      r_cos <= '0;
      r_err <= 1'b0;
    end else begin
      r_cv <= w_hit;
      if (w_hit) begin
        r_cp <= bus.req_phase[w_gid*PW +: PW];
        r_rr <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
        r_wp <= r_wp + 1'b1;
      end
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_id <= r_tag[r_rp];
        r_sin <= i_cordic_sin;
        r_cos <= i_cordic_cos;
        r_rp <= r_rp + 1'b1;
      end
      if (i_cordic_valid && r_cnt == '0) r_err <= 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_hit) - (AW+1)'(w_pop);
    end

  always_ff @(posedge i_clk)
    if (w_hit) r_tag[r_wp] <= w_gid;

`ifdef SINCOS_ARB_STATS_EN
  for (genvar k = 0; k < NREQ; k++) begin : g_cnt
    logic [15:0] r_gcnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_gcnt <= '0;
      else if (i_stats_clr) r_gcnt <= '0;
      else if (w_grant[k] && r_gcnt != 16'hFFFF) r_gcnt <= r_gcnt + 16'd1;
    assign o_grant_cnt[k*16 +: 16] = r_gcnt;
  end
`endif

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id = r_rsp_id;
  assign bus.rsp_sin = r_sin;
  assign bus.rsp_cos = r_cos;
  assign o_cordic_rst = ~i_rst_n;
  assign o_cordic_valid = r_cv;
  assign o_cordic_phase = r_cp;
  assign o_busy = (r_cnt != '0) | r_cv;
  assign o_err = r_err;
endmodule
